// File: rtl/serial_subtractor_if.sv
// Request/response bundle for the bit-serial subtractor: operands and START in,
// status and result out.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - BIN, LSB first, one bit per clock. The result and borrow
// are published in one step when the last bit is done, then DONE pulses for a cycle.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             d_bit, br_nx, last;
  logic [WIDTH-1:0] res_nx;

  // Full-subtractor cell working on the current LSBs of the shift registers.
  assign d_bit  = a_q[0] ^ b_q[0] ^ br_q;
  assign br_nx  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign res_nx = {d_bit, res_q[WIDTH-1:1]};
  assign last   = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    res_d   = res_q;
    dout_d  = dout_q;
    bout_d  = bout_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nx;
        res_d = res_nx;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          dout_d  = res_nx;
          bout_d  = br_nx;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status flags are registered copies of the next state so outputs come straight off flops.
    busy_d = (state_d == RUN);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      res_q   <= '0;
      dout_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      res_q   <= res_d;
      dout_q  <= dout_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.d    = dout_q;
  assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): expected results are queued
// on each accepted START and compared when DONE appears.
module tb_serial_subtractor;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    exp_t e;
    int   diff;
    diff   = int'(a) - int'(b) - int'(bin);
    e.d    = diff[W-1:0];
    e.bout = (diff < 0);
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.d !== '0) begin errors++; $display("FAIL reset_d got %h exp 00", bus.d); end
    checks++; if (bus.bout !== 1'b0) begin errors++; $display("FAIL reset_bout got %b exp 0", bus.bout); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One isolated operation with cycle-exact BUSY/DONE checks; operands are scrambled after accept.
  task automatic test_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    exp_t         e;
    logic [W-1:0] prev_d;
    prev_d = bus.d;
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.bin = bin;
    sb.push_back(model(a, b, bin));
    for (int c = 1; c <= W; c++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.a = ~a; bus.b = ~b; bus.bin = ~bin;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL op_busy c%0d got %b exp 1", c, bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL op_early_done c%0d got %b exp 0", c, bus.done); end
      checks++; if (bus.d !== prev_d) begin errors++; $display("FAIL op_d_hold c%0d got %h exp %h", c, bus.d, prev_d); end
    end
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL op_done got %b exp 1", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL op_busy_fin got %b exp 0", bus.busy); end
    checks++; if (bus.d !== e.d) begin errors++; $display("FAIL op_d a=%h b=%h bin=%b got %h exp %h", a, b, bin, bus.d, e.d); end
    checks++; if (bus.bout !== e.bout) begin errors++; $display("FAIL op_bout a=%h b=%h bin=%b got %b exp %b", a, b, bin, bus.bout, e.bout); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL op_done_pulse got %b exp 0", bus.done); end
    checks++; if (bus.d !== e.d) begin errors++; $display("FAIL op_d_idle_hold got %h exp %h", bus.d, e.d); end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int   ndone = 0;
    bus.start = 1'b1; bus.a = 8'd200; bus.b = 8'd50; bus.bin = 1'b0;
    sb.push_back(model(8'd200, 8'd50, 1'b0));
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.a = 8'd1; bus.b = 8'd2;
    @(negedge clk); bus.start = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checks++; if (bus.d !== e.d) begin errors++; $display("FAIL ignore_d got %h exp %h", bus.d, e.d); end
          checks++; if (bus.bout !== e.bout) begin errors++; $display("FAIL ignore_bout got %b exp %b", bus.bout, e.bout); end
        end
      end
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count got %0d exp 1", ndone); end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    bus.start = 1'b1; bus.a = 8'd77; bus.b = 8'd11; bus.bin = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b exp 0", bus.done); end
    checks++; if (bus.d !== '0) begin errors++; $display("FAIL rstmid_d got %h exp 00", bus.d); end
    checks++; if (bus.bout !== 1'b0) begin errors++; $display("FAIL rstmid_bout got %b exp 0", bus.bout); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", ndone); end
    test_op(8'd10, 8'd3, 1'b0);
  endtask

  // START held high with operands changing every cycle: accepts land every W+2 edges.
  task automatic test_back_to_back(input int nops);
    exp_t e;
    logic exp_done;
    int   last_done = -1;
    int   mis = 0;
    for (int n = 0; n <= (W + 2) * nops; n++) begin
      exp_done = (n % (W + 2) == W + 1);
      if (bus.done !== exp_done) begin
        mis++;
        if (mis <= 5) $display("FAIL b2b_done n=%0d got %b exp %b", n, bus.done, exp_done);
      end
      if (bus.done === 1'b1) begin
        if (last_done >= 0) begin
          checks++; if (n - last_done != W + 2) begin errors++; $display("FAIL b2b_spacing got %0d exp %0d", n - last_done, W + 2); end
        end
        last_done = n;
        if (sb.size() == 0) begin
          checks++; errors++; $display("FAIL b2b_unexpected_done n=%0d got done exp none", n);
        end else begin
          e = sb.pop_front();
          checks++; if (bus.d !== e.d) begin errors++; $display("FAIL b2b_d n=%0d got %h exp %h", n, bus.d, e.d); end
          checks++; if (bus.bout !== e.bout) begin errors++; $display("FAIL b2b_bout n=%0d got %b exp %b", n, bus.bout, e.bout); end
        end
      end
      bus.start = (n <= (W + 2) * (nops - 1));
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.bin   = 1'($urandom);
      if (bus.start && (n % (W + 2) == 0)) sb.push_back(model(bus.a, bus.b, bus.bin));
      @(negedge clk);
    end
    checks++; if (mis != 0) begin errors++; $display("FAIL b2b_done_timing got %0d bad cycles exp 0", mis); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_leftover got %0d exp 0", sb.size()); end
    bus.start = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_op(8'd100, 8'd37, 1'b0);
    test_op(8'd5, 8'd9, 1'b0);
    test_op(8'd0, 8'd0, 1'b1);
    test_op(8'hFF, 8'hFF, 1'b1);
    test_op(8'hFF, 8'h00, 1'b0);
    test_ignore_start();
    test_reset_mid();
    @(negedge clk);
    test_back_to_back(1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
